// File: rtl/cfa_frame_store.sv
// -----------------------------------------------------------------------------
// cfa_frame_store
//
// Frame buffer wrapped around a colour-filter-array demosaic core. It holds four
// planes (raw, green, red, blue) of memDepth words each and steps through a
// four-phase frame cycle:
//   IDLE    -> waits for go with a usable frameSize
//   LOAD    -> accepts frameSize raw pixels; green/red/blue are cleared as the
//              pixels arrive
//   PROCESS -> the demosaic core reads through the read port and writes
//              colour samples through the write port
//   DUMP    -> streams {green,red,blue} for addresses 0..frameSize-1
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   go, frameSize            frame start pulse and pixel count (sampled on go)
//   loadValid/loadData/loadReady  raw pixel input handshake
//   cfaStart                 one-cycle start pulse to the demosaic core
//   readAddress -> raw, greenRead, redRead, blueRead   registered read port
//   writeAddress, writeEnable[2:0]={g,r,b}, greenWrite/redWrite/blueWrite
//   outValid/outData/outLast/outReady  output stream, outData = {g,r,b}
//   frameDone                one-cycle pulse after the last output beat
//   busy                     high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module cfa_frame_store #(
  parameter int addressBitWidth = 17,
  parameter int dataBitWidth    = 12,
  parameter int memDepth        = 76800
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go,
  input  logic [addressBitWidth-1:0]    frameSize,
  input  logic                          loadValid,
  input  logic [dataBitWidth-1:0]       loadData,
  output logic                          loadReady,
  output logic                          cfaStart,
  input  logic [addressBitWidth-1:0]    readAddress,
  output logic [dataBitWidth-1:0]       raw,
  output logic [dataBitWidth-1:0]       greenRead,
  output logic [dataBitWidth-1:0]       redRead,
  output logic [dataBitWidth-1:0]       blueRead,
  input  logic [addressBitWidth-1:0]    writeAddress,
  input  logic [2:0]                    writeEnable,
  input  logic [dataBitWidth-1:0]       greenWrite,
  input  logic [dataBitWidth-1:0]       redWrite,
  input  logic [dataBitWidth-1:0]       blueWrite,
  output logic                          outValid,
  output logic [3*dataBitWidth-1:0]     outData,
  output logic                          outLast,
  input  logic                          outReady,
  output logic                          frameDone,
  output logic                          busy
);

  localparam int          IDX_W   = (memDepth > 1) ? $clog2(memDepth) : 1;
  localparam int unsigned DEPTH_U = memDepth;

  typedef logic [addressBitWidth-1:0] addr_t;
  typedef logic [dataBitWidth-1:0]    data_t;
  typedef logic [IDX_W-1:0]           idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PROCESS,
    S_DUMP
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  addr_t  frame_size_q, frame_size_d;
  addr_t  load_ptr_q, load_ptr_d;
  addr_t  write_cnt_q, write_cnt_d;
  addr_t  dump_ptr_q, dump_ptr_d;
  logic   cfa_start_q, cfa_start_d;
  logic   frame_done_q, frame_done_d;
  logic   out_valid_q, out_valid_d;
  logic   out_last_q, out_last_d;
  logic [3*dataBitWidth-1:0] out_data_q;
  data_t  raw_rd_q, green_rd_q, red_rd_q, blue_rd_q;

  data_t  raw_mem   [memDepth];
  data_t  green_mem [memDepth];
  data_t  red_mem   [memDepth];
  data_t  blue_mem  [memDepth];

  // ---------------------------------------------------------------------------
  // Qualifiers. rst masks every handshake so nothing is written in the reset
  // cycle, whatever state the FSM was in.
  // ---------------------------------------------------------------------------
  logic       size_ok;
  logic       load_fire;
  logic       load_last;
  logic       wr_in_range;
  logic       rd_in_range;
  logic [2:0] cfa_we;
  logic       cfa_any;
  logic       dump_issue;
  logic       out_fire;
  idx_t       load_idx, wr_idx, rd_idx, dump_idx;

  assign size_ok     = (frameSize != '0) && (32'(frameSize) <= DEPTH_U);
  assign loadReady   = (state_q == S_LOAD) && !rst;
  assign load_fire   = loadReady && loadValid;
  assign load_last   = (load_ptr_q == frame_size_q - addr_t'(1));
  assign wr_in_range = (32'(writeAddress) < DEPTH_U);
  assign rd_in_range = (32'(readAddress) < DEPTH_U);
  // Out-of-range writes still count toward the frame, they just touch no plane.
  assign cfa_any     = (state_q == S_PROCESS) && !rst && (writeEnable != 3'b000);
  assign cfa_we      = (cfa_any && wr_in_range) ? writeEnable : 3'b000;
  assign out_fire    = out_valid_q && outReady;
  // The output register doubles as the synchronous read stage of the internal
  // read port: it is refilled whenever it is empty or being drained, so a
  // continuously ready sink sees one beat per cycle.
  assign dump_issue  = (state_q == S_DUMP) && !rst && (dump_ptr_q < frame_size_q)
                       && (!out_valid_q || outReady);

  assign load_idx = load_ptr_q[IDX_W-1:0];
  assign wr_idx   = writeAddress[IDX_W-1:0];
  assign rd_idx   = readAddress[IDX_W-1:0];
  assign dump_idx = dump_ptr_q[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    frame_size_d = frame_size_q;
    load_ptr_d   = load_ptr_q;
    write_cnt_d  = write_cnt_q;
    dump_ptr_d   = dump_ptr_q;
    cfa_start_d  = 1'b0;
    frame_done_d = 1'b0;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;

    unique case (state_q)
      S_IDLE: begin
        if (go && size_ok) begin
          state_d      = S_LOAD;
          frame_size_d = frameSize;
          load_ptr_d   = '0;
          write_cnt_d  = '0;
          dump_ptr_d   = '0;
        end
      end

      S_LOAD: begin
        if (load_fire) begin
          if (load_last) begin
            state_d     = S_PROCESS;
            cfa_start_d = 1'b1;
          end else begin
            load_ptr_d = load_ptr_q + addr_t'(1);
          end
        end
      end

      S_PROCESS: begin
        // Bound is checked before the increment, so the counter stops at
        // frameSize and can never wrap.
        if (cfa_any && (write_cnt_q < frame_size_q)) begin
          write_cnt_d = write_cnt_q + addr_t'(1);
          if (write_cnt_q == frame_size_q - addr_t'(1)) begin
            state_d = S_DUMP;
          end
        end
      end

      S_DUMP: begin
        if (dump_issue) begin
          out_valid_d = 1'b1;
          out_last_d  = (dump_ptr_q == frame_size_q - addr_t'(1));
          dump_ptr_d  = dump_ptr_q + addr_t'(1);
        end else if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (out_fire && out_last_q) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          out_valid_d  = 1'b0;
          out_last_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      frame_size_q <= '0;
      load_ptr_q   <= '0;
      write_cnt_q  <= '0;
      dump_ptr_q   <= '0;
      cfa_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      raw_rd_q     <= '0;
      green_rd_q   <= '0;
      red_rd_q     <= '0;
      blue_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      frame_size_q <= frame_size_d;
      load_ptr_q   <= load_ptr_d;
      write_cnt_q  <= write_cnt_d;
      dump_ptr_q   <= dump_ptr_d;
      cfa_start_q  <= cfa_start_d;
      frame_done_q <= frame_done_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      if (dump_issue) begin
        out_data_q <= {green_mem[dump_idx], red_mem[dump_idx], blue_mem[dump_idx]};
      end
      // External read port: live in every state, returns pre-write data on a
      // same-address collision because the planes update at the same edge.
      if (rd_in_range) begin
        raw_rd_q   <= raw_mem[rd_idx];
        green_rd_q <= green_mem[rd_idx];
        red_rd_q   <= red_mem[rd_idx];
        blue_rd_q  <= blue_mem[rd_idx];
      end else begin
        raw_rd_q   <= '0;
        green_rd_q <= '0;
        red_rd_q   <= '0;
        blue_rd_q  <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Plane storage. LOAD and PROCESS are mutually exclusive, so each plane sees
  // at most one writer per cycle. The raw plane is only written by LOAD.
  // ---------------------------------------------------------------------------
  // NOTE: the planes have no reset; clearing RAM contents is not possible in a
  // single cycle and would prevent mapping to block memory.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      raw_mem[load_idx]   <= loadData;
      green_mem[load_idx] <= '0;
      red_mem[load_idx]   <= '0;
      blue_mem[load_idx]  <= '0;
    end
    if (cfa_we[2]) green_mem[wr_idx] <= greenWrite;
    if (cfa_we[1]) red_mem[wr_idx]   <= redWrite;
    if (cfa_we[0]) blue_mem[wr_idx]  <= blueWrite;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cfaStart  = cfa_start_q;
  assign raw       = raw_rd_q;
  assign greenRead = green_rd_q;
  assign redRead   = red_rd_q;
  assign blueRead  = blue_rd_q;
  assign outValid  = out_valid_q;
  assign outData   = out_data_q;
  assign outLast   = out_last_q;
  assign frameDone = frame_done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cfa_frame_store.sv
// -----------------------------------------------------------------------------
// tb_cfa_frame_store
//
// Self-checking bench for cfa_frame_store with a small plane depth. A model of
// the four planes (plain arrays) is updated from the frame rules: loaded pixels
// land in raw with zeroed colour planes, colour writes land only in PROCESS and
// only in range, and the dump must replay {g,r,b} for 0..frameSize-1.
// -----------------------------------------------------------------------------
module tb_cfa_frame_store;

  localparam int AW    = 8;
  localparam int DW    = 12;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            go;
  logic [AW-1:0]   frameSize;
  logic            loadValid;
  logic [DW-1:0]   loadData;
  logic            loadReady;
  logic            cfaStart;
  logic [AW-1:0]   readAddress;
  logic [DW-1:0]   raw, greenRead, redRead, blueRead;
  logic [AW-1:0]   writeAddress;
  logic [2:0]      writeEnable;
  logic [DW-1:0]   greenWrite, redWrite, blueWrite;
  logic            outValid;
  logic [3*DW-1:0] outData;
  logic            outLast;
  logic            outReady;
  logic            frameDone;
  logic            busy;

  always #5 clk = ~clk;

  cfa_frame_store #(
    .addressBitWidth(AW),
    .dataBitWidth   (DW),
    .memDepth       (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .frameSize   (frameSize),
    .loadValid   (loadValid),
    .loadData    (loadData),
    .loadReady   (loadReady),
    .cfaStart    (cfaStart),
    .readAddress (readAddress),
    .raw         (raw),
    .greenRead   (greenRead),
    .redRead     (redRead),
    .blueRead    (blueRead),
    .writeAddress(writeAddress),
    .writeEnable (writeEnable),
    .greenWrite  (greenWrite),
    .redWrite    (redWrite),
    .blueWrite   (blueWrite),
    .outValid    (outValid),
    .outData     (outData),
    .outLast     (outLast),
    .outReady    (outReady),
    .frameDone   (frameDone),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_raw [DEPTH];
  logic [DW-1:0] m_g   [DEPTH];
  logic [DW-1:0] m_r   [DEPTH];
  logic [DW-1:0] m_b   [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_plane(input int p, input int a);
    if (a >= DEPTH) return '0;
    case (p)
      0:       return m_raw[a];
      1:       return m_g[a];
      2:       return m_r[a];
      default: return m_b[a];
    endcase
  endfunction

  task automatic check_read(input string tag, input int a,
                            input logic [DW-1:0] e0, e1, e2, e3);
    check({tag, "_raw"},   raw,       e0);
    check({tag, "_green"}, greenRead, e1);
    check({tag, "_red"},   redRead,   e2);
    check({tag, "_blue"},  blueRead,  e3);
  endtask

  // Plain read cycle with no colour write.
  task automatic idle_read(input int a);
    logic [DW-1:0] e0, e1, e2, e3;
    e0 = exp_plane(0, a); e1 = exp_plane(1, a); e2 = exp_plane(2, a); e3 = exp_plane(3, a);
    writeEnable = 3'b000;
    readAddress = AW'(a);
    step();
    check_read("rd", a, e0, e1, e2, e3);
  endtask

  // Colour write while reading the same address: read must return old data.
  task automatic cfa_write(input int a, input logic [2:0] we,
                           input logic [DW-1:0] g, r, b);
    logic [DW-1:0] e0, e1, e2, e3;
    e0 = exp_plane(0, a); e1 = exp_plane(1, a); e2 = exp_plane(2, a); e3 = exp_plane(3, a);
    writeAddress = AW'(a);
    writeEnable  = we;
    greenWrite   = g;
    redWrite     = r;
    blueWrite    = b;
    readAddress  = AW'(a);
    step();
    writeEnable = 3'b000;
    check_read("rdw", a, e0, e1, e2, e3);
    if (a < DEPTH) begin
      if (we[2]) m_g[a] = g;
      if (we[1]) m_r[a] = r;
      if (we[0]) m_b[a] = b;
    end
  endtask

  // Starts a frame with go (in the current cycle) and loads n pixels.
  task automatic do_load(input int n, input bit gaps, input bit directed);
    int            acc;
    int            cyc;
    logic          v;
    logic [DW-1:0] d;
    acc = 0;
    cyc = 0;
    go = 1'b1;
    frameSize = AW'(n);
    loadValid = 1'b0;
    step();
    go = 1'b0;
    check("load_busy", busy, 1);
    check("load_ready", loadReady, 1);
    while (acc < n && cyc < 500) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = directed ? DW'(12'h100 + acc) : DW'($urandom);
      loadValid = v;
      loadData  = d;
      // A stray go during LOAD must be ignored.
      go        = gaps ? ($urandom_range(0, 3) == 0) : 1'b0;
      frameSize = AW'($urandom_range(1, DEPTH));
      check("load_ready_hold", loadReady, 1);
      if (v && loadReady) begin
        m_raw[acc] = d;
        m_g[acc]   = '0;
        m_r[acc]   = '0;
        m_b[acc]   = '0;
        acc++;
      end
      step();
      cyc++;
      if (acc < n) check("cfa_start_early", cfaStart, 0);
    end
    loadValid = 1'b0;
    go        = 1'b0;
    check("load_count", acc, n);
    check("load_ready_drop", loadReady, 0);
    check("cfa_start_pulse", cfaStart, 1);
    check("process_busy", busy, 1);
    readAddress = '0;
    step();
    check("cfa_start_single", cfaStart, 0);
  endtask

  task automatic do_process_random(input int n);
    int cnt;
    int cyc;
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < 500) begin
      check("proc_busy", busy, 1);
      go        = ($urandom_range(0, 3) == 0);
      frameSize = AW'($urandom_range(1, DEPTH));
      if ($urandom_range(0, 3) == 0) begin
        idle_read($urandom_range(0, DEPTH + 1));
      end else begin
        cfa_write($urandom_range(0, DEPTH + 1), 3'($urandom_range(1, 7)),
                  DW'($urandom), DW'($urandom), DW'($urandom));
        cnt++;
      end
      cyc++;
    end
    go = 1'b0;
    check("proc_count", cnt, n);
  endtask

  // Called in the first DUMP cycle (just after the edge of the last write).
  task automatic do_dump(input int n, input bit directed);
    int              beat;
    int              cyc;
    int              first;
    logic            prev_fire;
    logic            prev_stall;
    logic [3*DW-1:0] prev_data;
    logic [3*DW-1:0] e;
    beat = 0;
    cyc = 0;
    first = -1;
    prev_fire = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (beat < n && cyc < 300) begin
      outReady = directed ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
      // Colour writes outside PROCESS must be dropped.
      writeEnable  = 3'($urandom_range(0, 7));
      writeAddress = AW'($urandom_range(0, DEPTH - 1));
      greenWrite   = DW'($urandom);
      redWrite     = DW'($urandom);
      blueWrite    = DW'($urandom);
      if (prev_fire) check("dump_no_bubble", outValid, 1);
      if (outValid) begin
        if (first < 0) first = cyc;
        e = {m_g[beat], m_r[beat], m_b[beat]};
        check("dump_data", outData, e);
        check("dump_last", outLast, (beat == n - 1));
        if (prev_stall) check("dump_stable", outData, prev_data);
      end
      prev_stall = outValid && !outReady;
      prev_data  = outData;
      prev_fire  = outValid && outReady;
      if (prev_fire) beat++;
      step();
      cyc++;
    end
    writeEnable = 3'b000;
    outReady    = 1'b0;
    check("dump_beats", beat, n);
    check("dump_first_latency", (first >= 0 && first <= 2), 1);
    check("done_pulse", frameDone, 1);
    check("done_idle", busy, 0);
    check("done_valid_low", outValid, 0);
    step();
    check("done_single", frameDone, 0);
  endtask

  task automatic random_frame(input int n);
    do_load(n, 1'b1, 1'b0);
    do_process_random(n);
    do_dump(n, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    go = 1'b1;
    frameSize = AW'(3);
    loadValid = 1'b1;
    loadData = '0;
    readAddress = '0;
    writeAddress = '0;
    writeEnable = 3'b000;
    greenWrite = '0;
    redWrite = '0;
    blueWrite = '0;
    outReady = 1'b1;

    // Reset, with go held high to show rst wins.
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_load_ready", loadReady, 0);
    check("rst_cfa_start", cfaStart, 0);
    check("rst_out_valid", outValid, 0);
    check("rst_out_last", outLast, 0);
    check("rst_frame_done", frameDone, 0);
    check("rst_raw", raw, 0);
    check("rst_green", greenRead, 0);
    check("rst_red", redRead, 0);
    check("rst_blue", blueRead, 0);
    check("rst_out_data", outData, 0);
    rst = 1'b0;
    go = 1'b0;
    loadValid = 1'b0;
    outReady = 1'b0;

    // go with invalid sizes is ignored.
    go = 1'b1; frameSize = AW'(0);
    step();
    go = 1'b0;
    check("bad0_busy", busy, 0);
    check("bad0_ready", loadReady, 0);
    go = 1'b1; frameSize = AW'(DEPTH + 1);
    step();
    go = 1'b0;
    check("bad_big_busy", busy, 0);
    check("bad_big_ready", loadReady, 0);
    step();
    check("bad_big_still_idle", busy, 0);

    // Full-depth frame initialises every plane word.
    random_frame(DEPTH);

    // Directed frame of four pixels.
    do_load(4, 1'b0, 1'b1);
    readAddress = AW'(2);
    step();
    check("dir_raw2", raw, 12'h102);
    check("dir_green2", greenRead, 12'h000);
    cfa_write(1, 3'b100, 12'habc, 12'h555, 12'h000);
    readAddress = AW'(1);
    step();
    check("dir_green1", greenRead, 12'habc);
    check("dir_red1", redRead, 12'h000);
    cfa_write(DEPTH, 3'b111, 12'hfff, 12'hfff, 12'hfff);
    readAddress = AW'(DEPTH);
    step();
    check("oor_raw", raw, 12'h000);
    check("oor_green", greenRead, 12'h000);
    check("oor_red", redRead, 12'h000);
    check("oor_blue", blueRead, 12'h000);
    cfa_write(2, 3'b011, 12'h000, 12'h123, 12'h456);
    cfa_write(0, 3'b111, 12'h007, 12'h008, 12'h009);
    check("dir_dump_busy", busy, 1);
    do_dump(4, 1'b1);

    // Reset in LOAD after two pixels; a pixel offered during rst is dropped.
    go = 1'b1; frameSize = AW'(8);
    step();
    go = 1'b0;
    for (int i = 0; i < 2; i++) begin
      loadValid = 1'b1;
      loadData  = DW'($urandom);
      m_raw[i] = loadData; m_g[i] = '0; m_r[i] = '0; m_b[i] = '0;
      step();
    end
    rst = 1'b1;
    loadData = DW'($urandom);
    step();
    rst = 1'b0;
    loadValid = 1'b0;
    check("rstload_ready", loadReady, 0);
    check("rstload_busy", busy, 0);
    random_frame(2);

    // Reset in DUMP: frame abandoned, no frameDone.
    do_load(3, 1'b0, 1'b0);
    do_process_random(3);
    outReady = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    outReady = 1'b0;
    check("rstdump_done", frameDone, 0);
    check("rstdump_valid", outValid, 0);
    check("rstdump_data", outData, 0);
    check("rstdump_busy", busy, 0);
    step();
    check("rstdump_done_after", frameDone, 0);

    // Randomised frames.
    for (int k = 0; k < 6; k++) begin
      random_frame($urandom_range(1, DEPTH));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
